adder_share_ctrl: RTL and testbench

Sequencer and arbiter for the shared 4-bit ripple-carry adder datapath. Two requesters submit WIDTH-bit additions. The block grants one at a time, round-robin on ties, and feeds the operands nibble-serially through the external 4-bit adder (LSB nibble first), chaining carries through an internal carry register. It assembles the WIDTH-bit sum and carry-out and returns them under a valid/ready handshake.

---
 rtl/adder_share_ctrl_if.sv | 42 ++++
 rtl/adder_share_ctrl.sv | 116 +++++++++++
 tb/tb_adder_share_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/adder_share_ctrl_if.sv
// Bundles the requester, shared-adder and result signals of adder_share_ctrl.
// The slave modport is the controller's view. The master modport is the
// environment's view: the requesters, the 4-bit adder and the result consumer.
interface adder_share_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             cin0;
  logic             cin1;
  logic             gnt0;
  logic             gnt1;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_s;
  logic             add_cout;
  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;
  logic             busy;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, cin0, cin1,
    input  add_s, add_cout, res_ready,
    output gnt0, gnt1, add_a, add_b, add_cin,
    output res_valid, res_id, res_sum, res_cout, busy
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, cin0, cin1,
    output add_s, add_cout, res_ready,
    input  gnt0, gnt1, add_a, add_b, add_cin,
    input  res_valid, res_id, res_sum, res_cout, busy
  );
endinterface

// File: rtl/adder_share_ctrl.sv
// Arbiter and nibble sequencer for a shared external 4-bit adder.
// Two requesters are served one at a time, with round-robin on ties. The
// operands are fed LSB nibble first, and the carry is chained through
// carry_reg. The full sum and carry-out are returned under valid/ready.
module adder_share_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  adder_share_ctrl_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [CW+1:0]    base;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] sum_reg;
  logic             cin_reg;
  logic             carry_reg;
  logic             id_reg;
  logic             last_gnt;
  logic             valid_q;
  logic             busy_q;
  logic             sel0;
  logic             sel1;

  // Bit offset of the nibble currently being processed.
  always_comb base = {cnt, 2'b00};

  // Grant decode: a grant is issued only in IDLE. On a tie, the requester
  // that was not granted most recently wins.
  always_comb begin
    sel0     = bus.req0 & (~bus.req1 | last_gnt);
    sel1     = bus.req1 & (~bus.req0 | ~last_gnt);
    bus.gnt0 = (state == IDLE) & sel0;
    bus.gnt1 = (state == IDLE) & sel1;
  end

  // Shared adder drive: the current nibble is presented in RUN, and the
  // adder inputs are held at zero in every other state.
  always_comb begin
    bus.add_a   = '0;
    bus.add_b   = '0;
    bus.add_cin = 1'b0;
    if (state == RUN) begin
      bus.add_a   = opa[base +: 4];
      bus.add_b   = opb[base +: 4];
      bus.add_cin = (cnt == '0) ? cin_reg : carry_reg;
    end
  end

  // Result outputs come straight from registers and are stable throughout DONE.
  always_comb begin
    bus.res_valid = valid_q;
    bus.busy      = busy_q;
    bus.res_id    = id_reg;
    bus.res_sum   = sum_reg;
    bus.res_cout  = carry_reg;
  end

  // Control FSM: capture on grant, accumulate one nibble per cycle, then hold
  // the result until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      opa       <= '0;
      opb       <= '0;
      sum_reg   <= '0;
      cin_reg   <= 1'b0;
      carry_reg <= 1'b0;
      id_reg    <= 1'b0;
      last_gnt  <= 1'b1;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.gnt0 | bus.gnt1) begin
            opa      <= bus.gnt1 ? bus.a1 : bus.a0;
            opb      <= bus.gnt1 ? bus.b1 : bus.b0;
            cin_reg  <= bus.gnt1 ? bus.cin1 : bus.cin0;
            id_reg   <= bus.gnt1;
            last_gnt <= bus.gnt1;
            cnt      <= '0;
            sum_reg  <= '0;
            busy_q   <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_reg[base +: 4] <= bus.add_s;
          carry_reg          <= bus.add_cout;
          cnt                <= cnt + 1'b1;
          if (cnt == CW'(NIB - 1)) begin
            valid_q <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_share_ctrl.sv
// Scoreboard bench for adder_share_ctrl with a behavioural 4-bit adder.
module tb_adder_share_ctrl;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  typedef struct packed {
    logic             id;
    logic [WIDTH-1:0] sum;
    logic             cout;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  adder_share_ctrl_if #(.WIDTH(WIDTH)) bus();

  adder_share_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External shared adder.
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'd0, bus.add_cin};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Carry entering nibble k of a+b+cin, computed from the full-width sum.
  function automatic logic cin_into(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic cin, input int unsigned k);
    logic [63:0] m;
    logic [63:0] s;
    m = (64'd1 << (4 * k)) - 64'd1;
    s = ({48'd0, a} & m) + ({48'd0, b} & m) + {63'd0, cin};
    return s[4 * k];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: each accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got id %0d sum %h with an empty scoreboard", bus.res_id, bus.res_sum);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("res_id", {31'd0, bus.res_id}, {31'd0, e.id});
        chk("res_sum", {16'd0, bus.res_sum}, {16'd0, e.sum});
        chk("res_cout", {31'd0, bus.res_cout}, {31'd0, e.cout});
      end
    end
  end

  // Check the grant cycle, then every RUN cycle. Returns at the start of DONE.
  task automatic grant_and_run(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic [WIDTH-1:0] esum, input logic ecout,
                               input bit push);
    exp_t e;
    @(negedge clk);
    chk(id ? "gnt1" : "gnt0", {31'd0, (id ? bus.gnt1 : bus.gnt0)}, 32'd1);
    chk(id ? "gnt0_excl" : "gnt1_excl", {31'd0, (id ? bus.gnt0 : bus.gnt1)}, 32'd0);
    if (push) begin
      e.id = id; e.sum = esum; e.cout = ecout;
      q.push_back(e);
    end
    tick();
    if (id) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    for (int unsigned k = 0; k < NIB; k++) begin
      logic [WIDTH-1:0] sa;
      logic [WIDTH-1:0] sb;
      @(negedge clk);
      sa = a >> (4 * k);
      sb = b >> (4 * k);
      chk("add_cin", {31'd0, bus.add_cin}, {31'd0, cin_into(a, b, cin, k)});
      chk("add_a", {28'd0, bus.add_a}, {28'd0, sa[3:0]});
      chk("add_b", {28'd0, bus.add_b}, {28'd0, sb[3:0]});
      chk("busy_run", {31'd0, bus.busy}, 32'd1);
      chk("valid_run", {31'd0, bus.res_valid}, 32'd0);
      chk("no_gnt_run", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
      tick();
    end
  endtask

  task automatic finish_done();
    @(negedge clk);
    chk("res_valid", {31'd0, bus.res_valid}, 32'd1);
    chk("busy_done", {31'd0, bus.busy}, 32'd1);
    chk("no_gnt_done", {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    tick();
  endtask

  task automatic stall(input int unsigned n, input logic [WIDTH-1:0] esum, input logic ecout);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("stall_sum", {16'd0, bus.res_sum}, {16'd0, esum});
      chk("stall_cout", {31'd0, bus.res_cout}, {31'd0, ecout});
      chk("stall_no_gnt1", {31'd0, bus.gnt1}, 32'd0);
      tick();
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_valid", {31'd0, bus.res_valid}, 32'd1);
    tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"}, {30'd0, bus.gnt1, bus.gnt0}, 32'd0);
    chk({tag, "_add"}, {23'd0, bus.add_a, bus.add_b, bus.add_cin}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.res_valid}, 32'd0);
    chk({tag, "_id"}, {31'd0, bus.res_id}, 32'd0);
    chk({tag, "_sum"}, {16'd0, bus.res_sum}, 32'd0);
    chk({tag, "_cout"}, {31'd0, bus.res_cout}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    bus.cin0 = 1'b0; bus.cin1 = 1'b0;
    bus.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Tie after reset: requester 0 wins, with the nibble carry pattern of 0x1234+0x0FCD+1.
    bus.req0 = 1'b1; bus.a0 = 16'h1234; bus.b0 = 16'h0FCD; bus.cin0 = 1'b1;
    bus.req1 = 1'b1; bus.a1 = 16'h8000; bus.b1 = 16'h8000; bus.cin1 = 1'b0;
    grant_and_run(1'b0, 16'h1234, 16'h0FCD, 1'b1, 16'h2202, 1'b0, 1'b1);
    finish_done();

    // Pending requester 1 is granted in the first IDLE cycle.
    grant_and_run(1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    finish_done();

    // Another tie goes back to 0 (full ripple). Requester 1 waits through backpressure.
    bus.req0 = 1'b1; bus.a0 = 16'hFFFF; bus.b0 = 16'h0000; bus.cin0 = 1'b1;
    bus.req1 = 1'b1; bus.a1 = 16'h00F0; bus.b1 = 16'h0F10; bus.cin1 = 1'b0;
    bus.res_ready = 1'b0;
    grant_and_run(1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1);
    stall(3, 16'h0000, 1'b1);
    grant_and_run(1'b1, 16'h00F0, 16'h0F10, 1'b0, 16'h1000, 1'b0, 1'b1);
    finish_done();

    // Reset during RUN cycle 2 of 0xFFFF+0x0001: the partial result is dropped.
    bus.req0 = 1'b1; bus.a0 = 16'hFFFF; bus.b0 = 16'h0001; bus.cin0 = 1'b0;
    @(negedge clk);
    chk("abort_gnt0", {31'd0, bus.gnt0}, 32'd1);
    tick();
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, bus.busy}, 32'd1);
    tick();
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrun");
    repeat (2) begin
      @(negedge clk);
      chk("midrun_hold_valid", {31'd0, bus.res_valid}, 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    bus.req0 = 1'b1; bus.a0 = 16'h0001; bus.b0 = 16'h0001; bus.cin0 = 1'b0;
    grant_and_run(1'b0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b1);
    finish_done();

    @(negedge clk);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
